// File: rtl/upower_run_pkg.sv
// upower_run_pkg: shared types for the uPower run controller.
//   state_e  - sequencer states
//   MODE_*   - run-mode encodings on the mode input
package upower_run_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RESET = 3'd1,
        RUN   = 3'd2,
        STEP  = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [1:0] MODE_COUNT = 2'd0;
    localparam logic [1:0] MODE_HALT  = 2'd1;
    localparam logic [1:0] MODE_STEP  = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

endpackage

// File: rtl/upower_run_ctrl_if.sv
// upower_run_ctrl_if: control/status bundle between a run requester and the
// run controller.
//   master: drives start/mode/cycle_limit/step_req/halt_in/abort, observes status
//   slave : the controller; drives core_en/core_rst_n and the status outputs
interface upower_run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic [1:0]       mode;
    logic [CNT_W-1:0] cycle_limit;
    logic             step_req;
    logic             halt_in;
    logic             abort;
    logic             core_en;
    logic             core_rst_n;
    logic             busy;
    logic             done;
    logic             timeout;
    logic             aborted;
    logic             err;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, mode, cycle_limit, step_req, halt_in, abort,
        input  core_en, core_rst_n, busy, done, timeout, aborted, err, cycle_count
    );

    modport slave (
        input  start, mode, cycle_limit, step_req, halt_in, abort,
        output core_en, core_rst_n, busy, done, timeout, aborted, err, cycle_count
    );
endinterface

// File: rtl/upower_cycle_counter.sv
// upower_cycle_counter: W-bit saturating up-counter with equality compare.
//   clk_i, rst_ni - clock, async active-low reset
//   clr_i         - synchronous clear (wins over inc_i)
//   inc_i         - count one; holds at all-ones instead of wrapping
//   limit_i       - compare value
//   cnt_o         - current count (registered)
//   eq_o          - cnt_o == limit_i
module upower_cycle_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] cnt_o,
    output logic         eq_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)                    cnt_d = '0;
        else if (inc_i && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign eq_o  = (cnt_q == limit_i);
endmodule

// File: rtl/upower_run_ctrl.sv
// upower_run_ctrl: run sequencer for upower_core. Holds the core in reset for
// RST_CYCLES, then enables its clock in COUNT, HALT (with timeout) or STEP mode.
//   clock, reset_n - system clock, async active-low reset
//   bus (slave)    - start/mode/limit/step/halt/abort in; core_en, core_rst_n,
//                    busy/done/timeout/aborted/err and cycle_count out
// All outputs come straight from registers.
module upower_run_ctrl
    import upower_run_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 4,
    parameter int MAX_CYCLES = 1000
) (
    input  logic               clock,
    input  logic               reset_n,
    upower_run_ctrl_if.slave   bus
);
    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    if (RST_CYCLES < 1) begin : g_bad_rst
        $error("upower_run_ctrl: RST_CYCLES must be >= 1");
    end
    if (MAX_CYCLES < 1 || (longint'(MAX_CYCLES) >> CNT_W) != 0) begin : g_bad_max
        $error("upower_run_ctrl: MAX_CYCLES must be in 1 .. 2**CNT_W-1");
    end

    state_e           state_q, state_d;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] limit_q;
    logic             core_en_q, core_en_d, core_rst_n_q, core_rst_n_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             timeout_q, timeout_d, aborted_q, aborted_d, err_q, err_d;

    logic             idle_st, busy_st, start_ok, start_bad, halt_hit, tmo_hit;
    logic             rst_eq, run_eq;
    logic [CNT_W-1:0] run_cnt, run_lim;
    logic [RST_W-1:0] rst_cnt_unused;

    assign idle_st   = (state_q == IDLE) || (state_q == DONE);
    assign busy_st   = (state_q == RESET) || (state_q == RUN) || (state_q == STEP);
    assign start_ok  = bus.start && idle_st && (bus.mode != MODE_RSVD);
    assign start_bad = bus.start && idle_st && (bus.mode == MODE_RSVD);
    // halt_in only means something while the core is actually clocked
    assign halt_hit  = bus.halt_in && core_en_q;
    // Compare against budget-1: run_cnt counts completed enabled cycles, so
    // equality marks the final enabled cycle and the exit is taken at its end.
    assign run_lim   = (mode_q == MODE_HALT) ? CNT_W'(MAX_CYCLES - 1) : limit_q - 1'b1;
    assign tmo_hit   = (state_q == RUN) && (mode_q == MODE_HALT) && run_eq
                       && !halt_hit && !bus.abort;

    upower_cycle_counter #(.W(CNT_W)) u_run_cnt (
        .clk_i(clock), .rst_ni(reset_n), .clr_i(start_ok), .inc_i(core_en_q),
        .limit_i(run_lim), .cnt_o(run_cnt), .eq_o(run_eq)
    );

    upower_cycle_counter #(.W(RST_W)) u_rst_cnt (
        .clk_i(clock), .rst_ni(reset_n), .clr_i(start_ok), .inc_i(state_q == RESET),
        .limit_i(RST_W'(RST_CYCLES - 1)), .cnt_o(rst_cnt_unused), .eq_o(rst_eq)
    );

    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_ok) state_d = RESET;
            RESET: begin
                if (bus.abort)                                     state_d = DONE;
                else if (rst_eq) begin
                    if (mode_q == MODE_STEP)                       state_d = STEP;
                    else if (mode_q == MODE_COUNT && limit_q == '0) state_d = DONE;
                    else                                           state_d = RUN;
                end
            end
            RUN: begin
                if (bus.abort || run_eq || (mode_q == MODE_HALT && halt_hit))
                    state_d = DONE;
            end
            STEP:    if (bus.abort || halt_hit) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // output next values, derived from the state being entered
    always_comb begin
        core_en_d = 1'b0;
        if (state_d == RUN)
            core_en_d = 1'b1;
        else if (state_d == STEP && state_q == STEP)
            core_en_d = bus.step_req && !core_en_q;   // no queuing during a pulse
        core_rst_n_d = !((state_d == IDLE) || (state_d == RESET));
        busy_d       = (state_d == RESET) || (state_d == RUN) || (state_d == STEP);
        done_d       = (state_d == DONE);
        timeout_d    = start_ok ? 1'b0 : (timeout_q | tmo_hit);
        aborted_d    = start_ok ? 1'b0 : (aborted_q | (busy_st && bus.abort));
        err_d        = start_ok ? 1'b0 : (err_q | start_bad);
    end

    // output and run-parameter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            core_en_q    <= 1'b0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            aborted_q    <= 1'b0;
            err_q        <= 1'b0;
            mode_q       <= MODE_COUNT;
            limit_q      <= '0;
        end else begin
            core_en_q    <= core_en_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            aborted_q    <= aborted_d;
            err_q        <= err_d;
            if (start_ok) begin
                mode_q  <= bus.mode;
                limit_q <= bus.cycle_limit;
            end
        end
    end

    assign bus.core_en     = core_en_q;
    assign bus.core_rst_n  = core_rst_n_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.aborted     = aborted_q;
    assign bus.err         = err_q;
    assign bus.cycle_count = run_cnt;
endmodule

// File: tb/tb_upower_run_ctrl.sv
// tb_upower_run_ctrl: directed bench for upower_run_ctrl. Two instances:
// b0/u0 at CNT_W=32, RST_CYCLES=4, MAX_CYCLES=20 and b1/u1 at CNT_W=3,
// RST_CYCLES=2, MAX_CYCLES=5 for no-wrap/saturation cases.
module tb_upower_run_ctrl;
    import upower_run_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    upower_run_ctrl_if #(.CNT_W(32)) b0 ();
    upower_run_ctrl_if #(.CNT_W(3))  b1 ();

    upower_run_ctrl #(.CNT_W(32), .RST_CYCLES(4), .MAX_CYCLES(20)) u0 (
        .clock(clock), .reset_n(reset_n), .bus(b0.slave)
    );
    upower_run_ctrl #(.CNT_W(3), .RST_CYCLES(2), .MAX_CYCLES(5)) u1 (
        .clock(clock), .reset_n(reset_n), .bus(b1.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start0(input logic [1:0] m, input logic [31:0] lim, input logic ab);
        b0.mode = m; b0.cycle_limit = lim; b0.abort = ab; b0.start = 1'b1;
        tick();
        b0.start = 1'b0; b0.abort = 1'b0;
    endtask

    // Run u0 to done, counting reset-low and enabled cycles; raise halt_in
    // during the halt_at-th enabled cycle (0 = never).
    task automatic wait_done0(input string tag, input int halt_at,
                              output int rstlow, output int en);
        int n;
        n = 0; rstlow = 0; en = 0;
        while (!b0.done && n < 60) begin
            if (!b0.core_rst_n) rstlow++;
            if (b0.core_en) en++;
            b0.halt_in = (halt_at != 0) && b0.core_en && (en == halt_at);
            tick();
            n++;
        end
        b0.halt_in = 1'b0;
        chk({tag, "_done_reached"}, 64'(b0.done), 64'd1);
    endtask

    initial begin
        int rl, en, n;
        b0.start = 0; b0.mode = 0; b0.cycle_limit = 0; b0.step_req = 0; b0.halt_in = 0; b0.abort = 0;
        b1.start = 0; b1.mode = 0; b1.cycle_limit = 0; b1.step_req = 0; b1.halt_in = 0; b1.abort = 0;
        repeat (2) tick();
        chk("rst_outputs", {b0.core_en, b0.core_rst_n, b0.busy, b0.done, b0.timeout, b0.aborted, b0.err}, 7'b0);
        chk("rst_count", b0.cycle_count, 0);
        reset_n = 1'b1;
        tick();

        // COUNT, limit 5
        start0(MODE_COUNT, 5, 1'b0);
        wait_done0("cnt5", 0, rl, en);
        chk("cnt5_rstlow", rl, 4);
        chk("cnt5_en", en, 5);
        chk("cnt5_count", b0.cycle_count, 5);
        chk("cnt5_flags", {b0.busy, b0.core_en, b0.core_rst_n, b0.timeout, b0.aborted}, 5'b00100);

        // COUNT, limit 0
        start0(MODE_COUNT, 0, 1'b0);
        wait_done0("cnt0", 0, rl, en);
        chk("cnt0_rstlow", rl, 4);
        chk("cnt0_en", en, 0);
        chk("cnt0_count", b0.cycle_count, 0);
        chk("cnt0_timeout", b0.timeout, 0);

        // HALT on 7th enabled cycle; start together with abort in DONE (start wins)
        start0(MODE_HALT, 0, 1'b1);
        chk("startabort_busy", {b0.busy, b0.aborted, b0.done}, 3'b100);
        wait_done0("halt7", 7, rl, en);
        chk("halt7_en", en, 7);
        chk("halt7_count", b0.cycle_count, 7);
        chk("halt7_timeout", b0.timeout, 0);
        chk("halt7_core_en", b0.core_en, 0);

        // HALT never arrives -> timeout at MAX_CYCLES=20
        start0(MODE_HALT, 0, 1'b0);
        wait_done0("tmo", 0, rl, en);
        chk("tmo_en", en, 20);
        chk("tmo_count", b0.cycle_count, 20);
        chk("tmo_timeout", b0.timeout, 1);

        // STEP: three pulses 5 cycles apart, extra request during the 2nd pulse
        start0(MODE_STEP, 0, 1'b0);
        n = 0;
        while (!b0.core_rst_n && n < 20) begin tick(); n++; end
        chk("step_entered", {b0.core_rst_n, b0.busy}, 2'b11);
        chk("step_timeout_cleared", b0.timeout, 0);
        en = 0;
        for (int p = 0; p < 3; p++) begin
            b0.step_req = 1'b1;
            tick();
            b0.step_req = (p == 1);
            if (b0.core_en) en++;
            tick();
            b0.step_req = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (b0.core_en) en++;
                tick();
            end
        end
        chk("step_en", en, 3);
        chk("step_count", b0.cycle_count, 3);
        b0.abort = 1'b1;
        tick();
        b0.abort = 1'b0;
        chk("step_abort_flags", {b0.done, b0.aborted, b0.busy, b0.core_en}, 4'b1100);
        chk("step_abort_count", b0.cycle_count, 3);

        // Mid-run reset; start while busy is ignored
        start0(MODE_COUNT, 10, 1'b0);
        tick();
        b0.mode = MODE_RSVD; b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        chk("busy_start_ignored", {b0.err, b0.busy, b0.aborted}, 3'b010);
        n = 0;
        while (b0.cycle_count != 2 && n < 30) begin tick(); n++; end
        chk("midrun_count2", b0.cycle_count, 2);
        #2 reset_n = 1'b0;
        #1;
        chk("midrun_async_outputs", {b0.core_en, b0.core_rst_n, b0.busy, b0.done, b0.err}, 5'b0);
        chk("midrun_async_count", b0.cycle_count, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Reserved mode: err, stays IDLE; valid start clears err
        start0(MODE_RSVD, 3, 1'b0);
        chk("rsvd_flags", {b0.err, b0.busy, b0.core_en, b0.done}, 4'b1000);
        start0(MODE_COUNT, 1, 1'b0);
        chk("rsvd_cleared", {b0.err, b0.busy}, 2'b01);
        wait_done0("cnt1", 0, rl, en);
        chk("cnt1_count", b0.cycle_count, 1);

        // CNT_W=3: limit 7 reaches 7 without wrapping
        b1.mode = MODE_COUNT; b1.cycle_limit = 3'd7; b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        n = 0; en = 0; rl = 0;
        while (!b1.done && n < 40) begin
            if (b1.core_en) en++;
            if (!b1.core_rst_n) rl++;
            tick(); n++;
        end
        chk("w3_done", b1.done, 1);
        chk("w3_rstlow", rl, 2);
        chk("w3_en", en, 7);
        chk("w3_count", b1.cycle_count, 7);

        // CNT_W=3 STEP: nine steps saturate the count at 7
        b1.mode = MODE_STEP; b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        n = 0;
        while (!b1.core_rst_n && n < 20) begin tick(); n++; end
        for (int s = 0; s < 9; s++) begin
            b1.step_req = 1'b1;
            tick();
            b1.step_req = 1'b0;
            tick();
        end
        chk("w3_sat_count", b1.cycle_count, 7);
        b1.abort = 1'b1;
        tick();
        b1.abort = 1'b0;
        chk("w3_abort", {b1.done, b1.aborted, b1.timeout}, 3'b110);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
